// File: rtl/wb_port_scheduler.sv
// Y86-64 write-back scheduler: serializes 0..2 register writes per
// retiring instruction over one register-file write port.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wb_valid / wb_ready   retiring-instruction handshake (ready only in IDLE)
//   icode,cnd,rA,rB       instruction fields captured at accept
//   valE, valM            ALU result and memory read data
//   reg_we/waddr/wdata    register-file write port (registered)
//   pending_mask          registers with an outstanding write
//   wb_done               one-cycle pulse on the last write-back cycle
//   retired_cnt           completed instructions since reset (wraps)
module wb_port_scheduler #(
  parameter int RSP_IDX = 4,
  parameter int NREG    = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  output logic             reg_we,
  output logic [3:0]       reg_waddr,
  output logic [63:0]      reg_wdata,
  output logic [NREG-1:0]  pending_mask,
  output logic             wb_done,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR1  = 2'd1;
  localparam logic [1:0] S_WR2  = 2'd2;

  localparam logic [3:0] RSP   = RSP_IDX[3:0];
  localparam logic [3:0] NOREG = 4'hF;

  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [3:0]       waddr_q, waddr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic [NREG-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w2_en_q, w2_en_d;
  logic [3:0]       w2_addr_q, w2_addr_d;
  logic [63:0]      w2_data_q, w2_data_d;

  logic       e_en, m_en;
  logic [3:0] e_addr, m_addr;
  logic       e_ok, m_ok;
  logic       f_en, s_en;
  logic [3:0] f_addr;
  logic [63:0] f_data;
  logic       accept;

  function automatic logic [NREG-1:0] bit_of(input logic [3:0] a);
    bit_of = NREG'(1) << a;
  endfunction

  // Destination decode straight from the handshake inputs; only
  // used at the accept edge, so no separate capture stage is needed.
  always_comb begin
    e_en   = 1'b0;
    e_addr = rB;
    m_en   = 1'b0;
    m_addr = rA;
    unique case (1'b1)
      (icode == 4'd2): e_en = cnd;
      (icode == 4'd3),
      (icode == 4'd6): e_en = 1'b1;
      (icode == 4'd5): m_en = 1'b1;
      (icode == 4'd8),
      (icode == 4'd9),
      (icode == 4'd10): begin
        e_en   = 1'b1;
        e_addr = RSP;
      end
      (icode == 4'd11): begin
        e_en   = 1'b1;
        e_addr = RSP;
        m_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign e_ok   = e_en && (e_addr != NOREG);
  assign m_ok   = m_en && (m_addr != NOREG);
  assign f_en   = e_ok || m_ok;
  assign s_en   = e_ok && m_ok;
  assign f_addr = e_ok ? e_addr : m_addr;
  assign f_data = e_ok ? valE : valM;
  assign accept = wb_valid && (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    cnt_d     = done_q ? cnt_q + CNT_W'(1) : cnt_q;
    w2_en_d   = w2_en_q;
    w2_addr_d = w2_addr_q;
    w2_data_d = w2_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WR1;
          we_d    = f_en;
          if (f_en) begin
            waddr_d = f_addr;
            wdata_d = f_data;
          end
          done_d  = !s_en;
          pend_d  = (e_ok ? bit_of(e_addr) : '0)
                  | (m_ok ? bit_of(m_addr) : '0);
          w2_en_d   = s_en;
          w2_addr_d = m_addr;
          w2_data_d = valM;
        end
      end
      S_WR1: begin
        if (w2_en_q) begin
          state_d = S_WR2;
          we_d    = 1'b1;
          waddr_d = w2_addr_q;
          wdata_d = w2_data_q;
          done_d  = 1'b1;
          // Only the second destination remains outstanding.
          pend_d  = bit_of(w2_addr_q);
        end else begin
          state_d = S_IDLE;
          pend_d  = '0;
        end
      end
      S_WR2: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      pend_q    <= '0;
      cnt_q     <= '0;
      w2_en_q   <= 1'b0;
      w2_addr_q <= '0;
      w2_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      w2_en_q   <= w2_en_d;
      w2_addr_q <= w2_addr_d;
      w2_data_q <= w2_data_d;
    end
  end

  assign wb_ready     = (state_q == S_IDLE);
  assign reg_we       = we_q;
  assign reg_waddr    = waddr_q;
  assign reg_wdata    = wdata_q;
  assign wb_done      = done_q;
  assign pending_mask = pend_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: directed table, reset and wrap
// sequences, then random instructions against a write-list model.
module tb_wb_port_scheduler;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [3:0]    icode = '0;
  logic          cnd = 1'b0;
  logic [3:0]    rA = '0;
  logic [3:0]    rB = '0;
  logic [63:0]   valE = '0;
  logic [63:0]   valM = '0;
  logic          reg_we;
  logic [3:0]    reg_waddr;
  logic [63:0]   reg_wdata;
  logic [14:0]   pending_mask;
  logic          wb_done;
  logic [CW-1:0] retired_cnt;

  always #5 clk = ~clk;

  wb_port_scheduler #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .cnd(cnd), .rA(rA), .rB(rB),
    .valE(valE), .valM(valM),
    .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pending_mask(pending_mask),
    .wb_done(wb_done), .retired_cnt(retired_cnt)
  );

  typedef struct packed {
    logic          rdy;
    logic          we;
    logic [3:0]    a;
    logic [63:0]   d;
    logic          done;
    logic [14:0]   m;
    logic [CW-1:0] c;
  } obs_t;

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
  } wr_t;

  typedef wr_t wrq_t[$];

  typedef struct {
    string       name;
    logic [3:0]  ic;
    logic        cn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] ve;
    logic [63:0] vm;
    int          n;
    logic [3:0]  a1;
    logic [63:0] d1;
    logic [3:0]  a2;
    logic [63:0] d2;
  } vec_t;

  int          vecs = 0;
  int          errs = 0;
  int          retired = 0;
  logic [3:0]  last_a = '0;
  logic [63:0] last_d = '0;

  function automatic obs_t sample();
    obs_t o;
    o.rdy  = wb_ready;
    o.we   = reg_we;
    o.a    = reg_waddr;
    o.d    = reg_wdata;
    o.done = wb_done;
    o.m    = pending_mask;
    o.c    = retired_cnt;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t g;
    g = sample();
    vecs++;
    if (g !== e) begin
      errs++;
      $display("FAIL %s: got rdy=%0b we=%0b a=%h d=%h done=%0b m=%h c=%0d; want rdy=%0b we=%0b a=%h d=%h done=%0b m=%h c=%0d",
               name, g.rdy, g.we, g.a, g.d, g.done, g.m, g.c,
               e.rdy, e.we, e.a, e.d, e.done, e.m, e.c);
    end
  endtask

  task automatic idle_check(input string name);
    obs_t e;
    e.rdy  = 1'b1;
    e.we   = 1'b0;
    e.a    = last_a;
    e.d    = last_d;
    e.done = 1'b0;
    e.m    = '0;
    e.c    = CW'(retired);
    check(name, e);
  endtask

  // Spec-level write list: E-write first, then M-write, 0xF dropped.
  function automatic wrq_t model(input logic [3:0] ic, input logic cn,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [63:0] ve, input logic [63:0] vm);
    wrq_t q;
    wrq_t r;
    q = {};
    r = {};
    case (ic)
      4'd2:  if (cn) q.push_back('{rb, ve});
      4'd3, 4'd6: q.push_back('{rb, ve});
      4'd5:  q.push_back('{ra, vm});
      4'd8, 4'd9, 4'd10: q.push_back('{4'd4, ve});
      4'd11: begin
        q.push_back('{4'd4, ve});
        q.push_back('{ra, vm});
      end
      default: ;
    endcase
    foreach (q[i]) if (q[i].a != 4'hF) r.push_back(q[i]);
    return r;
  endfunction

  // Called at #1 after an edge in an IDLE cycle; returns likewise.
  task automatic run(input string name, input logic [3:0] ic,
                     input logic cn, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] ve,
                     input logic [63:0] vm, input wrq_t q);
    int   n;
    int   cyc;
    obs_t e;
    icode = ic; cnd = cn; rA = ra; rB = rb; valE = ve; valM = vm;
    wb_valid = 1'b1;
    n = q.size();
    cyc = (n == 0) ? 1 : n;
    @(posedge clk); #1;
    for (int k = 0; k < cyc; k++) begin
      // Inputs are don't-care while busy; valid must be ignored.
      wb_valid = 1'($urandom);
      icode = 4'($urandom);
      cnd = 1'($urandom);
      rA = 4'($urandom);
      rB = 4'($urandom);
      valE = {$urandom, $urandom};
      valM = {$urandom, $urandom};
      if (n > 0) begin
        last_a = q[k].a;
        last_d = q[k].d;
      end
      e.rdy  = 1'b0;
      e.we   = (n > 0);
      e.a    = last_a;
      e.d    = last_d;
      e.done = (k == cyc - 1);
      e.m    = '0;
      for (int j = k; j < n; j++) e.m = e.m | (15'(1) << q[j].a);
      e.c    = CW'(retired);
      check($sformatf("%s_c%0d", name, k + 1), e);
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    retired++;
    idle_check({name, "_idle"});
  endtask

  vec_t tbl[$];
  wrq_t q;
  obs_t e;

  initial begin
    tbl.push_back('{"irmovq",   4'd3,  0, 4'hF, 4'd2,  64'h1234, 64'h0,    1, 4'd2,  64'h1234, 4'd0, 64'h0});
    tbl.push_back('{"cmov_n",   4'd2,  0, 4'h0, 4'd3,  64'h55,   64'h0,    0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"cmov_y",   4'd2,  1, 4'h0, 4'd3,  64'h55,   64'h0,    1, 4'd3,  64'h55,   4'd0, 64'h0});
    tbl.push_back('{"popq",     4'd11, 0, 4'd6, 4'hF,  64'h100,  64'hBEEF, 2, 4'd4,  64'h100,  4'd6, 64'hBEEF});
    tbl.push_back('{"popq_rsp", 4'd11, 0, 4'd4, 4'hF,  64'h108,  64'h77,   2, 4'd4,  64'h108,  4'd4, 64'h77});
    tbl.push_back('{"mrmov_f",  4'd5,  0, 4'hF, 4'd1,  64'hAA,   64'hBB,   0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"mrmovq",   4'd5,  0, 4'd7, 4'd1,  64'hAA,   64'hBB,   1, 4'd7,  64'hBB,   4'd0, 64'h0});
    tbl.push_back('{"halt",     4'd0,  1, 4'd1, 4'd2,  64'h11,   64'h22,   0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"nop",      4'd1,  1, 4'd1, 4'd2,  64'h11,   64'h22,   0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"jxx",      4'd7,  1, 4'd1, 4'd2,  64'h11,   64'h22,   0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"rmmovq",   4'd4,  1, 4'd1, 4'd2,  64'h11,   64'h22,   0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"ic12",     4'd12, 1, 4'd1, 4'd2,  64'h11,   64'h22,   0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"opq",      4'd6,  0, 4'd1, 4'd14, 64'hCAFE, 64'h0,    1, 4'd14, 64'hCAFE, 4'd0, 64'h0});
    tbl.push_back('{"call",     4'd8,  0, 4'd1, 4'd2,  64'hF0,   64'h9,    1, 4'd4,  64'hF0,   4'd0, 64'h0});
    tbl.push_back('{"ret",      4'd9,  0, 4'd1, 4'd2,  64'hF8,   64'h9,    1, 4'd4,  64'hF8,   4'd0, 64'h0});
    tbl.push_back('{"pushq",    4'd10, 0, 4'd1, 4'd2,  64'hE8,   64'h9,    1, 4'd4,  64'hE8,   4'd0, 64'h0});
    tbl.push_back('{"popq_f",   4'd11, 0, 4'hF, 4'd2,  64'h200,  64'h9,    1, 4'd4,  64'h200,  4'd0, 64'h0});
    tbl.push_back('{"cmov_f",   4'd2,  1, 4'd1, 4'hF,  64'h5,    64'h9,    0, 4'd0,  64'h0,    4'd0, 64'h0});
    tbl.push_back('{"irmov_f",  4'd3,  1, 4'd1, 4'hF,  64'h5,    64'h9,    0, 4'd0,  64'h0,    4'd0, 64'h0});

    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    idle_check("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_check("post_reset");

    foreach (tbl[i]) begin
      q = {};
      if (tbl[i].n > 0) q.push_back('{tbl[i].a1, tbl[i].d1});
      if (tbl[i].n > 1) q.push_back('{tbl[i].a2, tbl[i].d2});
      run(tbl[i].name, tbl[i].ic, tbl[i].cn, tbl[i].ra, tbl[i].rb,
          tbl[i].ve, tbl[i].vm, q);
    end

    // Reset while popq sits in its first write cycle.
    icode = 4'd11; rA = 4'd6; valE = 64'h300; valM = 64'h400;
    wb_valid = 1'b1;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    e.rdy = 0; e.we = 1; e.a = 4'd4; e.d = 64'h300; e.done = 0;
    e.m = 15'h0050; e.c = CW'(retired);
    check("rst_wr1", e);
    #2 rst_n = 1'b0;
    #1;
    retired = 0;
    last_a = '0;
    last_d = '0;
    idle_check("rst_async");
    @(posedge clk); #1;
    idle_check("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_check("rst_no_wr2");
    @(posedge clk); #1;
    idle_check("rst_no_wr2b");

    // Counter wrap with a 3-bit counter.
    for (int i = 0; i < 9; i++) begin
      q = {};
      run($sformatf("wrap%0d", i), 4'd1, 1'b0, 4'd0, 4'd0,
          64'h0, 64'h0, q);
    end

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  ic;
      logic        cn;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] ve;
      logic [63:0] vm;
      ic = 4'($urandom_range(0, 15));
      cn = 1'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      q = model(ic, cn, ra, rb, ve, vm);
      run($sformatf("rnd%0d", i), ic, cn, ra, rb, ve, vm, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Sequences the register-file write-back for the sequential Y86-64 core over a single register-file write port, one write per cycle.
- Accepts one retiring instruction per handshake (icode, cnd, rA, rB, valE, valM). Decodes 0, 1 or 2 destination writes and issues them in a fixed order.
- Exports a pending-destination mask so decode can stall on in-flight writes. Counts retired instructions.

Parameters:
- RSP_IDX, 4, register index of %rsp (implicit destination for call/ret/pushq/popq)
- NREG, 15, number of architectural registers; index 4'hF means "no register"
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  retiring instruction presented
- wb_ready  output  1  scheduler can accept (high only in IDLE)
- icode  input  4  instruction code
- cnd  input  1  condition result (cmovXX)
- rA  input  4  rA field
- rB  input  4  rB field
- valE  input  64  ALU result
- valM  input  64  memory read data
- reg_we  output  1  register-file write enable
- reg_waddr  output  4  register-file write address
- reg_wdata  output  64  register-file write data
- pending_mask  output  15  bit i set = register i has an outstanding write
- wb_done  output  1  one-cycle pulse: instruction fully written back
- retired_cnt  output  CNT_W  instructions completed since reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wb_ready=1 after release, reg_we=0, reg_waddr=0, reg_wdata=0, pending_mask=0, wb_done=0, retired_cnt=0. An instruction in flight is dropped with no further writes.
- Accept occurs on a rising edge with wb_valid && wb_ready. All inputs are captured into internal registers at that edge; inputs are don't-care afterwards.
- Write-list decode (E-write first, then M-write):
  - icode 2 (cmovXX): E->rB only if cnd=1. If cnd=0, no write.
  - icode 3 (irmovq) and 6 (OPq): E->rB.
  - icode 5 (mrmovq): M->rA.
  - icode 8 (call), 9 (ret), 10 (pushq): E->RSP_IDX.
  - icode 11 (popq): E->RSP_IDX, then M->rA.
  - icodes 0, 1, 4, 7 and 12-15: no writes.
- Any write whose address is 4'hF is suppressed and removed from the list.
- FSM states:
  - IDLE: wb_ready=1. On accept, go to WR1.
  - WR1: If the list is empty, drive reg_we=0, pulse wb_done, and return to IDLE. Otherwise issue the first write. If a second write exists, go to WR2; else pulse wb_done and return to IDLE.
  - WR2: Issue the second write, pulse wb_done, return to IDLE.
- Latency: accept at edge N. First write is visible in cycle N+1 (registered outputs, committed at edge N+2). Second write is in cycle N+2. wb_done is asserted in the cycle of the last write, or in cycle N+1 for zero-write instructions.
- wb_ready=0 in WR1 and WR2, so there is no back-to-back accept. Throughput is 1 instruction per 2 cycles (3 for popq).
- popq %rsp (rA=RSP_IDX): both writes target RSP_IDX, in order E then M. The final value is valM, matching the Y86 rule that the popped value wins.
- reg_waddr and reg_wdata hold their last values when reg_we=0. reg_we is never high in IDLE.
- pending_mask:
  - Set at the accept edge for every non-suppressed destination.
  - A bit clears at the edge ending the cycle in which its last write to that register is issued.
  - The whole mask is 0 after wb_done.
- retired_cnt increments by 1 at the edge ending each wb_done cycle and wraps modulo 2^CNT_W.

Test Plan:
- Reset mid-popq: assert rst_n=0 during WR1 -> reg_we=0 immediately, pending_mask=0, retired_cnt=0, no WR2 write after release.
- irmovq: icode=3, rB=2, valE=0x1234 -> cycle N+1: reg_we=1, waddr=2, wdata=0x1234, wb_done=1; pending_mask=0x0004 during N+1 then 0.
- cmovXX: icode=2, rB=3, cnd=0 -> reg_we stays 0, wb_done at N+1, retired_cnt+1. Repeat with cnd=1, valE=0x55 -> write r3=0x55.
- popq: rA=6, valE=0x100, valM=0xBEEF -> N+1 writes r4=0x100; N+2 writes r6=0xBEEF with wb_done; wb_ready=0 for both cycles.
- popq %rsp: rA=4, valE=0x108, valM=0x77 -> writes r4=0x108 then r4=0x77; final r4=0x77.
- rA=0xF on mrmovq, and halt/nop/jXX -> no write, wb_done at N+1. Then 2^CNT_W completions (small CNT_W override, e.g. 3) -> retired_cnt wraps to 0.
